sha2_k_seq: RTL and testbench

SHA2_K_SEQ -- requirements
Module: sha2_k_seq

---
 rtl/sha2_pkg.sv | 54 +++++
 rtl/sha2_k_rom.sv | 39 +++
 rtl/sha2_k_seq.sv | 113 +++++++++++
 tb/tb_sha2_k_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// sha2_pkg -- shared definitions for the SHA-2 round-constant sequencer.
//   K256[0:63] : SHA-224/256 round constants (FIPS 180-4)
//   K512[0:79] : SHA-384/512 round constants (FIPS 180-4)
//   ROUNDS_256 / ROUNDS_512 and rounds_for() : round count per word width
//   seq_state_t : sequencer FSM states
package sha2_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic int rounds_for(input int word_w);
    return (word_w == 64) ? ROUNDS_512 : ROUNDS_256;
  endfunction

  localparam logic [31:0] K256 [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage

// File: rtl/sha2_k_rom.sv
// sha2_k_rom -- combinational two-port round-constant table.
//   WORD_W : 32 (K256, 64 entries) or 64 (K512, 80 entries); other widths are rejected
//   addr_a / data_a : lookup port A
//   addr_b / data_b : lookup port B
//   An index at or beyond the round count reads as zero.
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [6:0]        addr_a,
  output logic [WORD_W-1:0] data_a,
  input  logic [6:0]        addr_b,
  output logic [WORD_W-1:0] data_b
);

  // NOTE: the table is a constant, so there is no storage here to reset.
  generate
    if (WORD_W == 32) begin : g_k256
      always_comb begin
        // NOTE: every output gets a default first, so no latch is inferred.
        data_a = '0;
        data_b = '0;
        if (addr_a < 7'(ROUNDS_256)) data_a = K256[addr_a[5:0]];
        if (addr_b < 7'(ROUNDS_256)) data_b = K256[addr_b[5:0]];
      end
    end else if (WORD_W == 64) begin : g_k512
      always_comb begin
        data_a = '0;
        data_b = '0;
        if (addr_a < 7'(ROUNDS_512)) data_a = K512[addr_a];
        if (addr_b < 7'(ROUNDS_512)) data_b = K512[addr_b];
      end
    end else begin : g_bad_width
      $error("sha2_k_rom: WORD_W must be 32 or 64");
    end
  endgenerate

endmodule

// File: rtl/sha2_k_seq.sv
// sha2_k_seq -- SHA-2 round-constant sequencer with an independent lookup port.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a full K sequence (also chains a new one on the final handshake)
//   ready         : consumer takes the current k_o this cycle
//   abort         : drop the running sequence (beats start and ready)
//   k_o, k_valid  : current round constant (zero when not valid)
//   round_o, last : round index of k_o, final-round flag
//   busy          : sequencer is running
//   rd_en, rd_addr, rd_data : registered random-access lookup
module sha2_k_seq
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  input  logic              abort,
  output logic [WORD_W-1:0] k_o,
  output logic              k_valid,
  output logic [6:0]        round_o,
  output logic              last,
  output logic              busy,
  input  logic              rd_en,
  input  logic [6:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  localparam int         ROUNDS     = rounds_for(WORD_W);
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
  localparam logic [6:0] PENULT     = 7'(ROUNDS - 2);

  seq_state_t        state;
  logic [6:0]        round_q;
  logic [6:0]        prefetch_addr;
  logic [WORD_W-1:0] prefetch_k;
  logic [WORD_W-1:0] lookup_k;

  // The constant that k_o will need next is looked up from registered state
  // only: round+1 while mid-sequence, otherwise K[0] for a (re)start. This
  // keeps every input out of the combinational path to k_o.
  assign prefetch_addr = (state == RUN && round_q != LAST_ROUND) ? round_q + 7'd1 : 7'd0;

  sha2_k_rom #(.WORD_W(WORD_W)) u_rom (
    .addr_a (prefetch_addr),
    .data_a (prefetch_k),
    .addr_b (rd_addr),
    .data_b (lookup_k)
  );

  assign busy    = (state == RUN);
  assign k_valid = (state == RUN);
  assign round_o = round_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state   <= IDLE;
      round_q <= '0;
      k_o     <= '0;
      last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            round_q <= '0;
            k_o     <= prefetch_k;
            last    <= 1'b0;
          end
        end
        RUN: begin
          if (ready) begin
            if (round_q == LAST_ROUND) begin
              if (start) begin
                // Back-to-back sequence: wrap straight to round 0, no bubble.
                round_q <= '0;
                k_o     <= prefetch_k;
                last    <= 1'b0;
              end else begin
                state   <= IDLE;
                round_q <= '0;
                k_o     <= '0;
                last    <= 1'b0;
              end
            end else begin
              round_q <= round_q + 7'd1;
              k_o     <= prefetch_k;
              last    <= (round_q == PENULT);
            end
          end
        end
        default: begin
          state   <= IDLE;
          round_q <= '0;
          k_o     <= '0;
          last    <= 1'b0;
        end
      endcase
    end
  end

  // Lookup port shares only the table with the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= lookup_k;
    end
  end

endmodule

// File: tb/tb_sha2_k_seq.sv
// tb_sha2_k_seq -- scoreboard bench for sha2_k_seq at WORD_W=32 and WORD_W=64.
// Both instances share every input. Each stimulus cycle updates a sequence-level
// reference model and queues the expected outputs; a monitor pops and compares
// after each rising edge. Directed phases also compare against literal constants.
module tb_sha2_k_seq;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam int R_OF [0:1] = '{64, 80};

  // FIPS 180-4 SHA-512 constants; the SHA-256 constants are their upper halves.
  localparam logic [63:0] REF_K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef struct {
    logic        valid;
    logic [63:0] k;
    logic [6:0]  rnd;
    logic        last;
    logic        busy;
    logic [63:0] rd;
  } exp_t;

  logic        clk;
  logic        rst, start, ready, abort, rd_en;
  logic [6:0]  rd_addr;

  logic [31:0] k32, rd32;
  logic        kv32, last32, busy32;
  logic [6:0]  rnd32;
  logic [63:0] k64, rd64;
  logic        kv64, last64, busy64;
  logic [6:0]  rnd64;

  exp_t q32[$];
  exp_t q64[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: index 0 is the 32-bit instance, 1 the 64-bit one.
  bit          act [0:1];
  int          rnd [0:1];
  logic [63:0] rdv [0:1];

  sha2_k_seq #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .abort(abort),
    .k_o(k32), .k_valid(kv32), .round_o(rnd32), .last(last32), .busy(busy32),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd32)
  );

  sha2_k_seq #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .abort(abort),
    .k_o(k64), .k_valid(kv64), .round_o(rnd64), .last(last64), .busy(busy64),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic logic [63:0] ref_k(input int m, input int idx);
    logic [6:0] i7;
    if (idx < 0 || idx >= R_OF[m]) return '0;
    i7 = 7'(idx);
    if (m == 1) return REF_K[i7];
    return {32'd0, REF_K[i7][63:32]};
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model to what
  // the next rising edge should produce, queue it, and return just after that edge.
  task automatic step(input bit s, input bit r, input bit a, input bit x,
                      input bit e, input logic [6:0] addr);
    exp_t ex;
    @(negedge clk);
    start = s; ready = r; abort = a; rst = x; rd_en = e; rd_addr = addr;
    for (int m = 0; m < 2; m++) begin
      if (x || a) begin
        act[m] = 1'b0; rnd[m] = 0;
      end else if (!act[m]) begin
        if (s) begin act[m] = 1'b1; rnd[m] = 0; end
      end else if (r) begin
        if (rnd[m] == R_OF[m] - 1) begin
          rnd[m] = 0;
          if (!s) act[m] = 1'b0;
        end else begin
          rnd[m] = rnd[m] + 1;
        end
      end
      if (x) rdv[m] = '0;
      else if (e) rdv[m] = ref_k(m, int'(addr));
      ex.valid = act[m];
      ex.k     = act[m] ? ref_k(m, rnd[m]) : 64'd0;
      ex.rnd   = 7'(rnd[m]);
      ex.last  = act[m] && (rnd[m] == R_OF[m] - 1);
      ex.busy  = act[m];
      ex.rd    = rdv[m];
      if (m == 0) q32.push_back(ex);
      else q64.push_back(ex);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q32.size() > 0) begin
        mon_e = q32.pop_front();
        check("w32.k_valid", 64'(kv32),   64'(mon_e.valid));
        check("w32.k_o",     64'(k32),    mon_e.k);
        check("w32.round_o", 64'(rnd32),  64'(mon_e.rnd));
        check("w32.last",    64'(last32), 64'(mon_e.last));
        check("w32.busy",    64'(busy32), 64'(mon_e.busy));
        check("w32.rd_data", 64'(rd32),   mon_e.rd);
      end
      if (q64.size() > 0) begin
        mon_e = q64.pop_front();
        check("w64.k_valid", 64'(kv64),   64'(mon_e.valid));
        check("w64.k_o",     k64,         mon_e.k);
        check("w64.round_o", 64'(rnd64),  64'(mon_e.rnd));
        check("w64.last",    64'(last64), 64'(mon_e.last));
        check("w64.busy",    64'(busy64), 64'(mon_e.busy));
        check("w64.rd_data", rd64,        mon_e.rd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = 7'd0;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; rnd[m] = 0; rdv[m] = '0; end

    // Reset, with start/ready asserted to show reset overrides them.
    step(L, L, L, H, L, 7'd0);
    step(H, H, L, H, H, 7'd3);
    step(L, L, L, H, L, 7'd0);
    check("reset.k_valid32", 64'(kv32), 64'd0);
    check("reset.rd_data64", rd64, 64'd0);
    step(L, H, L, L, L, 7'd0);
    step(L, H, L, L, L, 7'd0);

    // Full sequence with ready held high.
    step(H, H, L, L, L, 7'd0);
    check("seq.first_k32", 64'(k32), 64'h428a2f98);
    check("seq.first_k64", k64, 64'h428a2f98d728ae22);
    for (int j = 1; j <= 81; j++) begin
      step(L, H, L, L, L, 7'd0);
      if (j == 63) begin
        check("seq.r63_k32",   64'(k32), 64'hc67178f2);
        check("seq.r63_last32", 64'(last32), 64'd1);
        check("seq.r63_k64",   k64, 64'hc67178f2e372532b);
      end
      if (j == 64) begin
        check("seq.end_valid32", 64'(kv32), 64'd0);
        check("seq.end_k32",     64'(k32), 64'd0);
      end
      if (j == 79) begin
        check("seq.r79_k64",    k64, 64'h6c44198c4a475817);
        check("seq.r79_last64", 64'(last64), 64'd1);
      end
      if (j == 80) check("seq.end_valid64", 64'(kv64), 64'd0);
    end

    // Five-cycle stall at round 10.
    step(H, H, L, L, L, 7'd0);
    repeat (10) step(L, H, L, L, L, 7'd0);
    for (int j = 0; j < 5; j++) begin
      step(L, L, L, L, L, 7'd0);
      check("stall.k32",     64'(k32), 64'h243185be);
      check("stall.round32", 64'(rnd32), 64'd10);
    end
    step(L, H, L, L, L, 7'd0);
    check("stall.after_k32", 64'(k32), 64'h550c7dc3);
    step(L, L, H, L, L, 7'd0);

    // Back-to-back sequences: start held through the final handshake.
    step(H, H, L, L, L, 7'd0);
    for (int j = 1; j <= 70; j++) begin
      step(H, H, L, L, L, 7'd0);
      if (j == 64) begin
        check("b2b.round32", 64'(rnd32), 64'd0);
        check("b2b.k32",     64'(k32), 64'h428a2f98);
        check("b2b.valid32", 64'(kv32), 64'd1);
      end
    end
    step(L, L, H, L, L, 7'd0);

    // Abort at round 20 together with start.
    step(H, H, L, L, L, 7'd0);
    repeat (20) step(L, H, L, L, L, 7'd0);
    check("abort.pre_round32", 64'(rnd32), 64'd20);
    step(H, H, H, L, L, 7'd0);
    check("abort.valid32", 64'(kv32), 64'd0);
    check("abort.k32",     64'(k32), 64'd0);

    // Reset at round 30; nothing resumes afterwards.
    step(H, H, L, L, L, 7'd0);
    repeat (30) step(L, H, L, L, L, 7'd0);
    step(L, H, L, H, L, 7'd0);
    check("rst_mid.valid64", 64'(kv64), 64'd0);
    repeat (5) step(L, H, L, L, L, 7'd0);
    check("rst_mid.still_idle32", 64'(kv32), 64'd0);

    // Lookup port during a running sequence.
    step(H, H, L, L, L, 7'd0);
    repeat (5) step(L, H, L, L, L, 7'd0);
    step(L, H, L, L, H, 7'd63);
    check("lookup.rd63_32", 64'(rd32), 64'hc67178f2);
    check("lookup.round32", 64'(rnd32), 64'd6);
    step(L, H, L, L, H, 7'd64);
    check("lookup.rd64_32", 64'(rd32), 64'd0);
    check("lookup.rd64_64", rd64, 64'hca273eceea26619c);
    check("lookup.k32",     64'(k32), 64'hab1c5ed5);
    step(L, H, L, L, L, 7'd5);
    check("lookup.hold32",  64'(rd32), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1, 7'($urandom_range(0, 127)));
    end

    step(L, L, L, L, L, 7'd0);
    #3;
    check("drain.q32", 64'(q32.size()), 64'd0);
    check("drain.q64", 64'(q64.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
